// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer pot scanner: scan FSM states,
// slot names and the default A2D channel map.
package eq_pkg;

  typedef enum logic [1:0] {
    GAP   = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    STORE = 2'd3
  } scan_state_t;

  // Scan slot order along the front panel
  localparam int SLOT_LP  = 0;
  localparam int SLOT_B1  = 1;
  localparam int SLOT_B2  = 2;
  localparam int SLOT_B3  = 3;
  localparam int SLOT_HP  = 4;
  localparam int SLOT_VOL = 5;

  // A2D channel per slot, slot 0 in the low three bits
  localparam logic [17:0] CH_MAP_DEFAULT = {3'd7, 3'd3, 3'd2, 3'd4, 3'd0, 3'd1};

endpackage

// File: rtl/eq_pot_scanner_pot_filter.sv
// pot_filter: single-write smoothing for one pot reading.
// new = (3*old + res + 2) >> 2, evaluated RES_W+2 bits wide so it never
// overflows; the first write after reset (loaded low) passes res through.
// Only instantiated when POT_SMOOTH_EN is defined.
module pot_filter
  import eq_pkg::*;
#(
  parameter int RES_W = 12
) (
  input  logic [RES_W-1:0] old_val,
  input  logic [RES_W-1:0] new_res,
  input  logic             loaded,
  output logic [RES_W-1:0] filt_val
);

  function automatic logic [RES_W-1:0] smooth_round(input logic [RES_W-1:0] old_v,
                                                    input logic [RES_W-1:0] new_v);
    logic [RES_W+1:0] acc;
    acc = {2'b00, old_v} + {1'b0, old_v, 1'b0} + {2'b00, new_v} + (RES_W+2)'(2);
    return RES_W'(acc >> 2);
  endfunction

  // Raw load on the first write, rounded 3:1 blend afterwards
  always_comb begin
    filt_val = new_res;
    if (loaded) filt_val = smooth_round(old_val, new_res);
  end

endmodule

// File: rtl/eq_pot_scanner.sv
// eq_pot_scanner: round-robin slide-pot scanner for the stereo equalizer.
// Walks the A2D through CH_MAP, keeps one reading per pot, and enables the
// amplifier AMP_DLY codec samples after the first complete scan.
// Optional feature macro: POT_SMOOTH_EN (smoothed pot storage).
module eq_pot_scanner
  import eq_pkg::*;
#(
  parameter int                  NUM_CH   = 6,
  parameter int                  RES_W    = 12,
  parameter logic [3*NUM_CH-1:0] CH_MAP   = CH_MAP_DEFAULT,
  parameter int                  SCAN_GAP = 16,
  parameter int                  CNV_TMO  = 4096,
  parameter int                  AMP_DLY  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cnv_cmplt,
  input  logic [RES_W-1:0]        res,
  input  logic                    valid,
  output logic                    strt_cnv,
  output logic [2:0]              chnnl,
  output logic [NUM_CH*RES_W-1:0] pot_out,
  output logic [NUM_CH-1:0]       pot_upd,
  output logic                    scan_done,
  output logic                    amp_on
);

  localparam int SLOT_W = $clog2(NUM_CH);
  localparam int GAP_W  = $clog2(SCAN_GAP + 1);
  localparam int TMO_W  = $clog2(CNV_TMO + 1);
  localparam int AMP_W  = $clog2(AMP_DLY + 1);

  scan_state_t       state;
  scan_state_t       state_nxt;
  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] slot_nxt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [AMP_W-1:0]  amp_cnt;
  logic [RES_W-1:0]  res_p0;
  logic [RES_W-1:0]  wr_val;
  logic              wr_chg;
  logic              last_slot;

  assign last_slot = (slot == SLOT_W'(NUM_CH - 1));
  assign slot_nxt  = last_slot ? '0 : slot + 1'b1;

`ifdef POT_SMOOTH_EN
  logic [NUM_CH-1:0] loaded;
  logic [RES_W-1:0]  old_val;

  assign old_val = pot_out[RES_W*int'(slot) +: RES_W];

  pot_filter #(
    .RES_W (RES_W)
  ) u_pot_filter (
    .old_val  (old_val),
    .new_res  (res_p0),
    .loaded   (loaded[slot]),
    .filt_val (wr_val)
  );

  assign wr_chg = (wr_val != old_val);

  // Per-slot flag: has this pot been written since reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loaded <= '0;
    end else if (state == STORE) begin
      loaded[slot] <= 1'b1;
    end
  end
`else
  assign wr_val = res_p0;
  assign wr_chg = 1'b1;
`endif

  // Next-state logic and the conversion request strobe
  always_comb begin
    state_nxt = state;
    strt_cnv  = 1'b0;
    case (state)
      GAP:   if (gap_cnt == GAP_W'(SCAN_GAP - 1)) state_nxt = START;
      START: begin
        strt_cnv  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnv_cmplt)                            state_nxt = STORE;
        else if (tmo_cnt == TMO_W'(CNV_TMO - 1)) state_nxt = GAP;
      end
      STORE: state_nxt = GAP;
      default: state_nxt = GAP;
    endcase
  end

  // State register plus the gap and timeout counters, each cleared outside its state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= GAP;
      gap_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= (state == GAP)  ? gap_cnt + 1'b1 : '0;
      tmo_cnt <= (state == WAIT) ? tmo_cnt + 1'b1 : '0;
    end
  end

  // Capture the A2D result as the conversion completes; written back in STORE
  always_ff @(posedge clk) begin
    if (state == WAIT && cnv_cmplt) res_p0 <= res;
  end

  // Slot sequencing, channel select, pot storage and update pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot      <= '0;
      chnnl     <= CH_MAP[2:0];
      pot_out   <= '0;
      pot_upd   <= '0;
      scan_done <= 1'b0;
    end else begin
      pot_upd <= '0;
      if (state == STORE) begin
        pot_out[RES_W*int'(slot) +: RES_W] <= wr_val;
        if (wr_chg) pot_upd[slot] <= 1'b1;
        if (last_slot) scan_done <= 1'b1;
        slot  <= slot_nxt;
        chnnl <= CH_MAP[3*int'(slot_nxt) +: 3];
      end
    end
  end

  // Amp-on delay: count codec samples once the first scan is complete
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      amp_cnt <= '0;
      amp_on  <= 1'b0;
    end else if (scan_done && valid && amp_cnt != AMP_W'(AMP_DLY)) begin
      amp_cnt <= amp_cnt + 1'b1;
      if (amp_cnt == AMP_W'(AMP_DLY - 1)) amp_on <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eq_pot_scanner.sv
// Directed testbench for eq_pot_scanner: a six-pot instance with a short
// gap, 64-clock timeout and 8-sample amp delay, plus a three-pot instance
// with a custom channel map. Builds with or without POT_SMOOTH_EN.
module tb_eq_pot_scanner;

  localparam int G   = 4;
  localparam int TMO = 64;
`ifdef POT_SMOOTH_EN
  localparam bit SMOOTH = 1'b1;
`else
  localparam bit SMOOTH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cnv_cmplt, valid;
  logic [11:0] res;
  logic        strt_cnv, scan_done, amp_on;
  logic [2:0]  chnnl;
  logic [71:0] pot_out;
  logic [5:0]  pot_upd;

  logic        cnv_cmplt_b, valid_b;
  logic [11:0] res_b;
  logic        strt_cnv_b, scan_done_b, amp_on_b;
  logic [2:0]  chnnl_b;
  logic [35:0] pot_out_b;
  logic [2:0]  pot_upd_b;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  eq_pot_scanner #(
    .NUM_CH(6), .RES_W(12), .SCAN_GAP(G), .CNV_TMO(TMO), .AMP_DLY(8)
  ) dut (
    .clk(clk), .rst(rst), .cnv_cmplt(cnv_cmplt), .res(res), .valid(valid),
    .strt_cnv(strt_cnv), .chnnl(chnnl), .pot_out(pot_out), .pot_upd(pot_upd),
    .scan_done(scan_done), .amp_on(amp_on)
  );

  eq_pot_scanner #(
    .NUM_CH(3), .RES_W(12), .CH_MAP(9'({3'd5, 3'd6, 3'd2})),
    .SCAN_GAP(G), .CNV_TMO(TMO), .AMP_DLY(8)
  ) dut_b (
    .clk(clk), .rst(rst), .cnv_cmplt(cnv_cmplt_b), .res(res_b), .valid(valid_b),
    .strt_cnv(strt_cnv_b), .chnnl(chnnl_b), .pot_out(pot_out_b), .pot_upd(pot_upd_b),
    .scan_done(scan_done_b), .amp_on(amp_on_b)
  );

  // Wait for the next strt_cnv; exp_k >= 0 also checks how many clocks it took
  task automatic wait_strt(input int exp_k, input string name);
    int k;
    bit hit;
    k = 0;
    hit = 1'b0;
    while (!hit && k < 2000) begin
      @(negedge clk);
      k++;
      if (strt_cnv) hit = 1'b1;
    end
    checks++;
    if (!hit || (exp_k >= 0 && k != exp_k)) begin
      errors++;
      $display("FAIL %s: strt_cnv seen=%0d after %0d clocks, required 1 after %0d", name, hit, k, exp_k);
    end
  endtask

  // Serve one conversion from the START cycle through the STORE write-back
  task automatic convert(input logic [2:0] exp_ch, input int slot, input logic [11:0] r,
                         input logic [11:0] exp_val, input logic exp_upd, input int dly,
                         input int nvalid, input string name);
    logic [5:0] exp_u;
    checks++;
    if (chnnl !== exp_ch) begin
      errors++;
      $display("FAIL %s chnnl at start: got %0d required %0d", name, chnnl, exp_ch);
    end
    for (int i = 0; i < dly; i++) begin
      valid = (i % 2 == 0) && (i < 2 * nvalid);
      @(negedge clk);
    end
    valid = 1'b0;
    checks++;
    if (chnnl !== exp_ch) begin
      errors++;
      $display("FAIL %s chnnl held in wait: got %0d required %0d", name, chnnl, exp_ch);
    end
    cnv_cmplt = 1'b1;
    res = r;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    res = 12'hABC;
    @(negedge clk);
    exp_u = exp_upd ? (6'd1 << slot) : 6'd0;
    checks++;
    if (pot_out[12*slot +: 12] !== exp_val) begin
      errors++;
      $display("FAIL %s pot slot %0d: got %h required %h", name, slot, pot_out[12*slot +: 12], exp_val);
    end
    checks++;
    if (pot_upd !== exp_u) begin
      errors++;
      $display("FAIL %s pot_upd: got %b required %b", name, pot_upd, exp_u);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cnv_cmplt = 1'b0; valid = 1'b0; res = '0;
    cnv_cmplt_b = 1'b0; valid_b = 1'b0; res_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({strt_cnv, chnnl, pot_upd, scan_done, amp_on} !== {1'b0, 3'd1, 6'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset outputs: strt=%b ch=%0d upd=%b done=%b amp=%b required 0 1 0 0 0",
               strt_cnv, chnnl, pot_upd, scan_done, amp_on);
    end
    checks++;
    if (pot_out !== 72'd0) begin
      errors++;
      $display("FAIL reset pot_out: got %h required 0", pot_out);
    end
    rst = 1'b0;
    // strt_cnv is high in the clock after SCAN_GAP idle clocks
    wait_strt(G, "first strt after reset");
  endtask

  task automatic test_scan();
    logic [2:0] chs [6];
    chs = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
    for (int i = 0; i < 6; i++) begin
      convert(chs[i], i, 12'h100 + 12'(chs[i]), 12'h100 + 12'(chs[i]), 1'b1, 40,
              (i == 0) ? 5 : 0, "scan");
      checks++;
      if (scan_done !== (i == 5)) begin
        errors++;
        $display("FAIL scan_done after slot %0d: got %b required %b", i, scan_done, i == 5);
      end
      wait_strt(G, "scan gap");
    end
    checks++;
    if (pot_out !== {12'h107, 12'h103, 12'h102, 12'h104, 12'h100, 12'h101}) begin
      errors++;
      $display("FAIL full scan pot_out: got %h", pot_out);
    end
    checks++;
    if (amp_on !== 1'b0) begin
      errors++;
      $display("FAIL amp_on after scan: got %b required 0", amp_on);
    end
  endtask

  task automatic test_timeout();
    logic [71:0] saved;
    convert(3'd1, 0, 12'h101, 12'h101, !SMOOTH, 4, 0, "wrap slot0");
    wait_strt(G, "wrap gap");
    convert(3'd0, 1, 12'h2AA, SMOOTH ? 12'h16B : 12'h2AA, 1'b1, 4, 0, "slot1 second pass");
    wait_strt(G, "slot1 gap");
    saved = pot_out;
    checks++;
    if (chnnl !== 3'd4) begin
      errors++;
      $display("FAIL timeout slot chnnl: got %0d required 4", chnnl);
    end
    wait_strt(1 + TMO + G, "retry after timeout");
    checks++;
    if (chnnl !== 3'd4) begin
      errors++;
      $display("FAIL retry chnnl: got %0d required 4", chnnl);
    end
    checks++;
    if (pot_out !== saved) begin
      errors++;
      $display("FAIL timeout wrote pot_out: got %h required %h", pot_out, saved);
    end
    convert(3'd4, 2, 12'h155, SMOOTH ? 12'h118 : 12'h155, 1'b1, 4, 0, "slot2 after retry");
    wait_strt(G, "slot2 gap");
  endtask

  task automatic test_amp();
    for (int n = 1; n <= 8; n++) begin
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      checks++;
      if (amp_on !== (n == 8)) begin
        errors++;
        $display("FAIL amp_on after valid %0d: got %b required %b", n, amp_on, n == 8);
      end
      @(negedge clk);
    end
    for (int n = 0; n < 3; n++) begin
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (amp_on !== 1'b1) begin
      errors++;
      $display("FAIL amp_on hold: got %b required 1", amp_on);
    end
  endtask

  task automatic test_rst_mid();
    wait_strt(-1, "strt before mid reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({strt_cnv, chnnl, scan_done, amp_on} !== {1'b0, 3'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async reset: strt=%b ch=%0d done=%b amp=%b required 0 1 0 0",
               strt_cnv, chnnl, scan_done, amp_on);
    end
    checks++;
    if (pot_out !== 72'd0) begin
      errors++;
      $display("FAIL async reset pot_out: got %h required 0", pot_out);
    end
    @(negedge clk);
    rst = 1'b0;
    cnv_cmplt = 1'b1;
    res = 12'hFFF;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    // one of the SCAN_GAP+1 clocks was spent on the stray pulse
    wait_strt(G - 1, "strt after mid reset");
    checks++;
    if (pot_out !== 72'd0 || pot_upd !== 6'd0) begin
      errors++;
      $display("FAIL stray cnv_cmplt: pot_out=%h upd=%b required 0 0", pot_out, pot_upd);
    end
  endtask

  task automatic test_values();
    logic [11:0] s0_res [4];
    logic [11:0] s0_smooth [4];
    logic [2:0]  chs [6];
    s0_res    = '{12'h000, 12'h400, 12'h400, 12'h400};
    s0_smooth = '{12'h000, 12'h100, 12'h1C0, 12'h250};
    chs = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
    for (int r = 0; r < 4; r++) begin
      convert(3'd1, 0, s0_res[r], SMOOTH ? s0_smooth[r] : s0_res[r],
              SMOOTH ? (r != 0) : 1'b1, 2, 0, "slot0 sequence");
      wait_strt(G, "slot0 seq gap");
      for (int i = 1; i < 6; i++) begin
        convert(chs[i], i, 12'h100 + 12'(chs[i]), 12'h100 + 12'(chs[i]),
                SMOOTH ? (r == 0) : 1'b1, 2, 0, "other slots");
        wait_strt(G, "other slot gap");
      end
    end
  endtask

  task automatic test_num_ch3();
    logic [2:0] seq [4];
    int k;
    seq = '{3'd2, 3'd6, 3'd5, 3'd2};
    for (int i = 0; i < 4; i++) begin
      k = 0;
      while (!strt_cnv_b && k < 2000) begin
        @(negedge clk);
        k++;
      end
      checks++;
      if (strt_cnv_b !== 1'b1 || chnnl_b !== seq[i]) begin
        errors++;
        $display("FAIL three-pot chnnl %0d: strt=%b got %0d required %0d", i, strt_cnv_b, chnnl_b, seq[i]);
      end
      if (i < 3) begin
        @(negedge clk);
        cnv_cmplt_b = 1'b1;
        res_b = 12'h200 + 12'(i);
        @(negedge clk);
        cnv_cmplt_b = 1'b0;
        @(negedge clk);
        checks++;
        if (pot_out_b[12*i +: 12] !== 12'h200 + 12'(i)) begin
          errors++;
          $display("FAIL three-pot slot %0d: got %h required %h", i, pot_out_b[12*i +: 12], 12'h200 + 12'(i));
        end
      end
    end
    checks++;
    if (scan_done_b !== 1'b1) begin
      errors++;
      $display("FAIL three-pot scan_done: got %b required 1", scan_done_b);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_timeout();
    test_amp();
    test_rst_mid();
    test_values();
    test_num_ch3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eq_pot_scanner.md
# eq_pot_scanner

Parametrised round-robin slide-pot scanner for the stereo equalizer. Sequences the A2D SPI interface through a programmable list of A2D channels and holds one registered RES_W-bit reading per band/volume pot. Gates the amplifier on once every pot has been read and the codec queues have run for a set number of samples. Sits between the A2D interface and the equalizer core, and replaces the fixed six-pot slide interface and the top-level amp-on delay logic.

## Interface
- NUM_CH, default 6: number of pots scanned (2..8).
- RES_W, default 12: A2D result width.
- CH_MAP, default {3'd7,3'd3,3'd2,3'd4,3'd0,3'd1}: packed 3-bit A2D channel per scan slot; slot i uses CH_MAP[3*i+:3]. Slot order is LP, B1, B2, B3, HP, VOL.
- SCAN_GAP, default 16: idle clocks between the end of one conversion and the next strt_cnv (≥1).
- CNV_TMO, default 4096: clocks allowed in WAIT before the conversion is abandoned.
- AMP_DLY, default 1024: codec valid pulses counted after the first full scan before amp_on asserts.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- cnv_cmplt  in  1  conversion-done pulse from the A2D interface.
- res  in  RES_W  A2D result; valid when cnv_cmplt is high.
- valid  in  1  codec sample-valid pulse.
- strt_cnv  out  1  one-clock conversion request.
- chnnl  out  3  A2D channel for the current slot.
- pot_out  out  NUM_CH*RES_W  packed readings; slot i is at [RES_W*i+:RES_W].
- pot_upd  out  NUM_CH  one-clock pulse, per slot, when that slot's reading changes.
- scan_done  out  1  sticky; high after the first complete pass over all slots.
- amp_on  out  1  sticky amplifier enable.

## Operation
- FSM states and transitions:
  - GAP: counts SCAN_GAP clocks, then goes to START.
  - START: pulses strt_cnv for one clock, then goes to WAIT.
  - WAIT: on cnv_cmplt goes to STORE; on timeout goes to GAP.
  - STORE: writes the slot, advances slot, goes to GAP.
- Slot index:
  - Advances 0..NUM_CH-1 and wraps to 0 after the last slot.
  - chnnl = CH_MAP[3*slot+:3] and is registered, so it is stable from START through WAIT.
- STORE writes res into pot_out slot `slot` and pulses pot_upd[slot].
- cnv_cmplt seen in any state other than WAIT is ignored.
- Timeout: after CNV_TMO clocks in WAIT, return to GAP with no write and the same slot. The slot is retried.
- scan_done sets in the STORE of slot NUM_CH-1 on the first pass.
- amp_on:
  - Once scan_done is high, a counter counts valid pulses.
  - amp_on sets when the count reaches AMP_DLY.
  - The counter saturates and amp_on holds until rst.
  - valid pulses before scan_done are not counted.
- Arithmetic: pot storage is unsigned RES_W bits. The amp counter is clog2(AMP_DLY+1) bits.

## Timing
- Reset values:
  - Outputs: strt_cnv=0, chnnl=CH_MAP[2:0], pot_out=0, pot_upd=0, scan_done=0, amp_on=0.
  - Internal: state=GAP, slot=0, all counters 0.
- First strt_cnv is SCAN_GAP+1 clocks after rst deasserts.
- pot_out and pot_upd update on the clock after cnv_cmplt is sampled in WAIT. That is 1-cycle latency.
- Per-slot period is SCAN_GAP + 2 + A2D conversion time.
- amp_on rises on the clock after the AMP_DLY-th counted valid.
- If valid and the scan_done-setting STORE occur in the same cycle, that valid is not counted.
- rst asserted mid-conversion: everything clears immediately. A late cnv_cmplt after release is ignored, because the FSM is in GAP.

## Configuration
- POT_SMOOTH_EN defined:
  - STORE writes (3*old + res + 2) >> 2, computed RES_W+2 bits wide.
  - The first write to each slot after reset loads res raw, tracked by per-slot loaded flags.
  - pot_upd pulses only when the stored value actually changes.
- POT_SMOOTH_EN undefined: raw res is stored and pot_upd pulses on every STORE.

## Structure
- Shared package eq_pkg holds:
  - The FSM state enum (GAP, START, WAIT, STORE).
  - The slot name constants SLOT_LP..SLOT_VOL.
  - The default CH_MAP constant.
- One sub-module, pot_filter: per-write smoothing datapath, present only under POT_SMOOTH_EN.
- Everything else is a single module.

## Test plan
- Reset then model A2D returning res=0x100+chnnl after 40 clocks:
  - strt_cnv pulses with chnnl sequence 1,0,4,2,3,7 and wraps to 1.
  - Slot i holds 0x101,0x100,0x104,0x102,0x103,0x107.
  - scan_done is high after the sixth STORE.
- Withhold cnv_cmplt on slot 2 for CNV_TMO=64 clocks:
  - FSM returns to GAP with no write.
  - Next strt_cnv carries chnnl=4 again.
- AMP_DLY=8:
  - 5 valid pulses before scan_done, then 8 after: amp_on rises one clock after the 8th counted pulse and stays high.
- Assert rst while in WAIT, release it, then pulse a stray cnv_cmplt:
  - No pot_out change.
  - strt_cnv occurs SCAN_GAP+1 clocks after release.
- POT_SMOOTH_EN with slot 0 fed 0x000 then 0x400 repeatedly:
  - Slot 0 goes 0x000, 0x100, 0x1C0, 0x250.
  - pot_upd stops once the value settles.
- NUM_CH=3, CH_MAP={3'd5,3'd6,3'd2}: chnnl sequence is 2,6,5,2.
